// File: rtl/counter91.sv
// -----------------------------------------------------------------------------
// counter91 -- load-triggered interval timer.
//
// A rising edge that samples ld=1 loads a 7-bit down-counter with CYCLES-1 and
// clears dn. Each following edge with ld=0 counts down. The first edge that
// finds the counter already at zero raises dn, which lands exactly CYCLES edges
// after the last load edge. The counter then parks at zero; it never wraps and
// never re-triggers on its own. Only another load starts a new interval.
//
// ld doubles as the block's reset. It is synchronous and active-high, and there
// is no asynchronous reset. State is undefined until the first load edge.
//
// Build option:
//   COUNTER91_PULSE_EN  undefined (default): dn is sticky once raised.
//                       defined: dn is high for exactly one cycle per load
//                       sequence. A "fired" flag, cleared by ld, remembers that
//                       the pulse was already issued. Both builds behave the
//                       same up to and including the rising edge of dn.
//
// Parameters:
//   CYCLES  edges from a load edge until dn asserts, legal range 2..127
//
// Ports:
//   clk  in   single clock, rising edge only
//   ld   in   synchronous load / reset, active high
//   dn   out  done flag, driven straight from a flop
// -----------------------------------------------------------------------------
module counter91 #(
    parameter int CYCLES = 91
) (
    input  logic clk,
    input  logic ld,
    output logic dn
);

    localparam logic [6:0] LOAD_VAL = 7'(CYCLES - 1);

    logic [6:0] r_cnt;
    logic       r_dn;
    logic       w_cnt_zero;

    assign w_cnt_zero = (r_cnt == 7'd0);

`ifdef COUNTER91_PULSE_EN
    logic r_fired;

    always_ff @(posedge clk) begin
        if (ld) begin
            r_cnt   <= LOAD_VAL;
            r_dn    <= 1'b0;
            r_fired <= 1'b0;
        end else if (!w_cnt_zero) begin
            r_cnt   <= r_cnt - 7'd1;
            r_dn    <= 1'b0;
        end else begin
            // Counter is parked at zero. Raise dn only on the first such edge.
            r_dn    <= ~r_fired;
            r_fired <= 1'b1;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (ld) begin
            r_cnt <= LOAD_VAL;
            r_dn  <= 1'b0;
        end else if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 7'd1;
            r_dn  <= 1'b0;
        end else begin
            // Counter is parked at zero, so dn latches high until the next load.
            r_dn  <= 1'b1;
        end
    end
`endif

    assign dn = r_dn;

endmodule

// File: tb/tb_counter91.sv
// -----------------------------------------------------------------------------
// Directed testbench for counter91. One DUT uses the default CYCLES=91 and a
// second uses CYCLES=2. Inputs change 1 ns after a rising edge, and dn is
// sampled 1 ns after the edge under test. Expected values are hand-derived
// edge counts measured from the last load edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_counter91;

    logic clk = 1'b0;
    logic ld  = 1'b0;
    logic dn;
    logic ld2 = 1'b0;
    logic dn2;

    int checks   = 0;
    int failures = 0;

    counter91 dut (
        .clk (clk),
        .ld  (ld),
        .dn  (dn)
    );

    counter91 #(.CYCLES(2)) dut2 (
        .clk (clk),
        .ld  (ld2),
        .dn  (dn2)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Idle edges while the state is still undefined, then one load edge.
    task automatic test_reset();
        ld  = 1'b0;
        ld2 = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        ld  = 1'b1;
        ld2 = 1'b1;
        tick();
        checks++;
        if (dn !== 1'b0) begin
            failures++;
            $display("FAIL reset_dn: got %b want 0", dn);
        end
        checks++;
        if (dn2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_dn2: got %b want 0", dn2);
        end
        ld  = 1'b0;
        ld2 = 1'b0;
    endtask

    // Single load already applied: dn is low through edge 90, high at 91,
    // and still high at 96 (sticky) or low after 91 (pulse).
    task automatic test_count();
        for (int e = 1; e <= 90; e++) begin
            tick();
            checks++;
            if (dn !== 1'b0) begin
                failures++;
                $display("FAIL count_low edge=%0d: got %b want 0", e, dn);
            end
        end
        tick();
        checks++;
        if (dn !== 1'b1) begin
            failures++;
            $display("FAIL count_rise edge=91: got %b want 1", dn);
        end
        for (int e = 92; e <= 96; e++) begin
            tick();
            checks++;
`ifdef COUNTER91_PULSE_EN
            if (dn !== 1'b0) begin
                failures++;
                $display("FAIL count_after edge=%0d: got %b want 0", e, dn);
            end
`else
            if (dn !== 1'b1) begin
                failures++;
                $display("FAIL count_hold edge=%0d: got %b want 1", e, dn);
            end
`endif
        end
    endtask

    // ld held for 3 edges. The count starts from the third one.
    task automatic test_multi_load();
        ld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (dn !== 1'b0) begin
                failures++;
                $display("FAIL multi_load_edge=%0d: got %b want 0", i, dn);
            end
        end
        ld = 1'b0;
        for (int e = 1; e <= 90; e++) begin
            tick();
            checks++;
            if (dn !== 1'b0) begin
                failures++;
                $display("FAIL multi_low edge=%0d: got %b want 0", e, dn);
            end
        end
        tick();
        checks++;
        if (dn !== 1'b1) begin
            failures++;
            $display("FAIL multi_rise edge=91: got %b want 1", dn);
        end
    endtask

    // Load, run 50 edges, then reload. dn must wait 91 edges from the reload.
    task automatic test_midcount();
        ld = 1'b1;
        tick();
        ld = 1'b0;
        for (int e = 1; e <= 50; e++) tick();
        checks++;
        if (dn !== 1'b0) begin
            failures++;
            $display("FAIL mid_before_reload: got %b want 0", dn);
        end
        ld = 1'b1;
        tick();
        ld = 1'b0;
        for (int e = 1; e <= 90; e++) begin
            tick();
            checks++;
            if (dn !== 1'b0) begin
                failures++;
                $display("FAIL mid_low edge=%0d: got %b want 0", e, dn);
            end
        end
        tick();
        checks++;
        if (dn !== 1'b1) begin
            failures++;
            $display("FAIL mid_rise edge=91: got %b want 1", dn);
        end
    endtask

    // dn has just risen. A reload drops it, and it rises again 91 edges later.
    task automatic test_reload_done();
        ld = 1'b1;
        tick();
        ld = 1'b0;
        checks++;
        if (dn !== 1'b0) begin
            failures++;
            $display("FAIL reload_drop: got %b want 0", dn);
        end
        for (int e = 1; e <= 90; e++) tick();
        checks++;
        if (dn !== 1'b0) begin
            failures++;
            $display("FAIL reload_edge90: got %b want 0", dn);
        end
        tick();
        checks++;
        if (dn !== 1'b1) begin
            failures++;
            $display("FAIL reload_rise edge=91: got %b want 1", dn);
        end
        // 21 more edges: sticky stays high, pulse stays low (no wrap / re-fire).
        for (int e = 92; e <= 112; e++) begin
            tick();
            checks++;
`ifdef COUNTER91_PULSE_EN
            if (dn !== 1'b0) begin
                failures++;
                $display("FAIL pulse_tail edge=%0d: got %b want 0", e, dn);
            end
`else
            if (dn !== 1'b1) begin
                failures++;
                $display("FAIL sticky_tail edge=%0d: got %b want 1", e, dn);
            end
`endif
        end
    endtask

    // Shortest legal interval.
    task automatic test_cycles2();
        ld2 = 1'b1;
        tick();
        ld2 = 1'b0;
        checks++;
        if (dn2 !== 1'b0) begin
            failures++;
            $display("FAIL c2_load: got %b want 0", dn2);
        end
        tick();
        checks++;
        if (dn2 !== 1'b0) begin
            failures++;
            $display("FAIL c2_edge1: got %b want 0", dn2);
        end
        tick();
        checks++;
        if (dn2 !== 1'b1) begin
            failures++;
            $display("FAIL c2_edge2: got %b want 1", dn2);
        end
        tick();
        checks++;
`ifdef COUNTER91_PULSE_EN
        if (dn2 !== 1'b0) begin
            failures++;
            $display("FAIL c2_edge3: got %b want 0", dn2);
        end
`else
        if (dn2 !== 1'b1) begin
            failures++;
            $display("FAIL c2_edge3: got %b want 1", dn2);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_count();
        test_multi_load();
        test_midcount();
        test_reload_done();
        test_cycles2();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter91.md
COUNTER91 -- requirements
Module: counter91

Interface
REQ-001 Parameter: CYCLES, default 91, number of clock edges after a load until dn asserts; legal range 2..127.
REQ-002 clk  input  1  single clock; all state updates on rising edge only.
REQ-003 ld  input  1  synchronous active-high reset/load; sampled on rising clk; no asynchronous reset.
REQ-004 dn  output  1  done flag, driven directly from a flop, no combinational path from ld.

Function
REQ-005 Internal 7-bit down-counter (cnt) plus a dn flop; no other state.
REQ-006 Load edge: a rising edge sampling ld=1 sets cnt=CYCLES-1 and dn=0.
REQ-007 Count edge: a rising edge sampling ld=0 with cnt!=0 decrements cnt by 1 and keeps dn=0.
REQ-008 Terminal edge: a rising edge sampling ld=0 with cnt==0 sets dn=1.
REQ-009 Timing, counted from the load edge (edge 0): dn=0 after edges 1..CYCLES-1; dn=1 after edge CYCLES (edge 91 by default).
REQ-010 Once dn=1 with ld=0: cnt holds at 0 and dn stays 1 indefinitely; no wrap-around, no re-trigger.
REQ-011 ld=1 held for several edges: every such edge is a load edge; the count starts from the last edge sampling ld=1.
REQ-012 ld=1 mid-count or while dn=1: restarts per REQ-006; dn falls after that edge.
REQ-013 Decrement never underflows; cnt stays in 0..CYCLES-1.

Reset
REQ-014 ld is the reset; after any edge sampling ld=1: dn=0, cnt=CYCLES-1.
REQ-015 Before the first load edge, dn and cnt are undefined; users apply ld before relying on dn.
REQ-016 No reset-state dependence other than REQ-014; a single ld cycle fully initialises the block.

Configuration
REQ-017 Macro COUNTER91_PULSE_EN selects how dn behaves at completion.
REQ-018 COUNTER91_PULSE_EN not defined (default): dn is sticky per REQ-010.
REQ-019 COUNTER91_PULSE_EN defined: dn=1 for exactly one cycle (after edge CYCLES), then 0 until the next load sequence completes; cnt still holds at 0; needs one extra internal "fired" flag cleared by ld.
REQ-020 Both builds are identical in timing up to and including the rising edge of dn.

Verification
REQ-021 Idle 10 edges, ld=1 for 1 edge, then ld=0 -> dn=0 after edges 1..90, dn=1 after edge 91, still 1 after edge 96 (default build).
REQ-022 ld=1 for 3 consecutive edges, then ld=0 -> dn rises exactly 91 edges after the third ld edge.
REQ-023 Load, run 50 edges, ld=1 for 1 edge -> dn stays 0 until 91 edges after the second load edge.
REQ-024 Load, wait until dn=1, ld=1 for 1 edge -> dn=0 after that edge; dn=1 again 91 edges later.
REQ-025 COUNTER91_PULSE_EN defined, load -> dn=1 after edge 91 only; dn=0 after edge 92 and for 20 further edges.
REQ-026 CYCLES=2, load -> dn=0 after edge 1, dn=1 after edge 2.
